// File: rtl/umi_fir_bank_pkg.sv
`default_nettype none
// ============================================================================
// umi_fir_bank_pkg : opcodes, address map, FSM states and width helpers
// Revision: 1.0
// ============================================================================
package umi_fir_bank_pkg;

    localparam logic [4:0] REQ_READ   = 5'h01;
    localparam logic [4:0] REQ_WRITE  = 5'h03;
    localparam logic [4:0] REQ_POSTED = 5'h05;
    localparam logic [4:0] RESP_READ  = 5'h02;
    localparam logic [4:0] RESP_WRITE = 5'h04;

    localparam logic [11:0] ADDR_SAMPLE = 12'h000;
    localparam logic [11:0] ADDR_RESULT = 12'h008;
    localparam logic [11:0] ADDR_COEF   = 12'h400;
    localparam logic [11:0] ADDR_STATUS = 12'h7F0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_RESP = 2'd2
    } fir_state_t;

    // Headroom of clog2(NTAPS) bits lets NTAPS full-scale products sum without overflow.
    function automatic int fir_accw(input int sw, input int ntaps);
        return 2 * sw + $clog2(ntaps);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : umi_fir_bank_pkg
`default_nettype wire

// File: rtl/umi_fir_bank_regs.sv
`default_nettype none
// ============================================================================
// umi_fir_bank_regs : shared coefficients, per-channel sample histories,
//                     result registers and result-valid flags
// Revision: 1.0
// ============================================================================
module umi_fir_bank_regs
    import umi_fir_bank_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int NTAPS = 8,
    parameter int SW    = 16,
    parameter int ACCW  = fir_accw(SW, NTAPS),
    parameter int CHW   = idx_width(NCH),
    parameter int TW    = idx_width(NTAPS)
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            clear,
    input  logic            coef_we,
    input  logic [TW-1:0]   coef_widx,
    input  logic [SW-1:0]   coef_wdata,
    input  logic [TW-1:0]   coef_ridx,
    output logic [SW-1:0]   coef_rdata,
    input  logic            shift_en,
    input  logic [CHW-1:0]  shift_ch,
    input  logic [SW-1:0]   shift_data,
    input  logic [CHW-1:0]  mac_ch,
    input  logic [TW-1:0]   mac_tap,
    output logic [SW-1:0]   mac_coef,
    output logic [SW-1:0]   mac_x,
    input  logic            res_we,
    input  logic [CHW-1:0]  res_wch,
    input  logic [ACCW-1:0] res_wdata,
    input  logic            res_rd,
    input  logic [CHW-1:0]  res_rch,
    output logic [ACCW-1:0] res_rdata,
    output logic [NCH-1:0]  valid_flags
);

    logic [SW-1:0]   r_coef [NTAPS];
    logic [SW-1:0]   r_hist [NCH][NTAPS];
    logic [ACCW-1:0] r_res  [NCH];
    logic [NCH-1:0]  r_valid;

    // Coefficients survive a STATUS clear; only nreset wipes them.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int k = 0; k < NTAPS; k++) r_coef[k] <= '0;
        end else if (coef_we) begin
            for (int k = 0; k < NTAPS; k++) begin
                if (TW'(k) == coef_widx) r_coef[k] <= coef_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < NTAPS; k++) r_hist[c][k] <= '0;
                r_res[c] <= '0;
            end
            r_valid <= '0;
        end else if (clear) begin
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < NTAPS; k++) r_hist[c][k] <= '0;
                r_res[c] <= '0;
            end
            r_valid <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (shift_en && shift_ch == CHW'(c)) begin
                    r_hist[c][0] <= shift_data;
                    for (int k = 1; k < NTAPS; k++) r_hist[c][k] <= r_hist[c][k-1];
                end
                if (res_we && res_wch == CHW'(c)) begin
                    r_res[c]   <= res_wdata;
                    r_valid[c] <= 1'b1;
                end else if (res_rd && res_rch == CHW'(c)) begin
                    r_valid[c] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        coef_rdata = '0;
        mac_coef   = '0;
        mac_x      = '0;
        res_rdata  = '0;
        for (int k = 0; k < NTAPS; k++) begin
            if (TW'(k) == coef_ridx) coef_rdata = r_coef[k];
            if (TW'(k) == mac_tap)   mac_coef   = r_coef[k];
        end
        for (int c = 0; c < NCH; c++) begin
            if (CHW'(c) == mac_ch) begin
                for (int k = 0; k < NTAPS; k++) begin
                    if (TW'(k) == mac_tap) mac_x = r_hist[c][k];
                end
            end
            if (CHW'(c) == res_rch) res_rdata = r_res[c];
        end
    end

    assign valid_flags = r_valid;

endmodule : umi_fir_bank_regs
`default_nettype wire

// File: rtl/umi_fir_bank.sv
`default_nettype none
// ============================================================================
// umi_fir_bank : bank of NCH FIR filters behind a UMI device port; one tap
//                per cycle multiply-accumulate after each SAMPLE write
// Revision: 1.0
// ============================================================================
module umi_fir_bank
    import umi_fir_bank_pkg::*;
#(
    parameter int DW    = 128,
    parameter int AW    = 64,
    parameter int CW    = 32,
    parameter int NCH   = 4,
    parameter int NTAPS = 8,
    parameter int SW    = 16
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          udev_req_valid,
    input  logic [CW-1:0] udev_req_cmd,
    input  logic [AW-1:0] udev_req_dstaddr,
    input  logic [AW-1:0] udev_req_srcaddr,
    input  logic [DW-1:0] udev_req_data,
    output logic          udev_req_ready,
    output logic          udev_resp_valid,
    output logic [CW-1:0] udev_resp_cmd,
    output logic [AW-1:0] udev_resp_dstaddr,
    output logic [AW-1:0] udev_resp_srcaddr,
    output logic [DW-1:0] udev_resp_data,
    input  logic          udev_resp_ready
);

    localparam int ACCW = fir_accw(SW, NTAPS);
    localparam int CHW  = idx_width(NCH);
    localparam int TW   = idx_width(NTAPS);

    if (ACCW > DW || CW < 16 || AW < 12 || NCH < 1 || NCH > 16 ||
        NTAPS < 2 || NTAPS > 64) begin : g_param_check
        $error("umi_fir_bank: unsupported parameter combination");
    end

    fir_state_t r_state;
    fir_state_t w_next;

    logic                   r_run;
    logic                   r_err;
    logic [TW-1:0]          r_tap;
    logic signed [ACCW-1:0] r_acc;
    logic [CHW-1:0]         r_mac_ch;
    logic                   r_mac_posted;
    logic [CW-1:0]          r_resp_cmd;
    logic [AW-1:0]          r_resp_dst;
    logic [AW-1:0]          r_resp_src;
    logic [DW-1:0]          r_resp_data;

    logic                     w_accept;
    logic [4:0]               w_op;
    logic [11:0]              w_a;
    logic                     w_is_rd, w_is_wr, w_is_post, w_is_any_wr, w_op_ok;
    logic                     w_ch_ok, w_tap_ok;
    logic                     w_sel_sample, w_sel_result, w_sel_coef, w_sel_status;
    logic                     w_addr_ok;
    logic [CHW-1:0]           w_ch;
    logic [TW-1:0]            w_tap;
    logic [DW-1:0]            w_rdata;
    logic [CW-1:0]            w_resp_cmd;
    logic [SW-1:0]            w_coef_rdata, w_mac_coef, w_mac_x;
    logic [ACCW-1:0]          w_res_rdata;
    logic [NCH-1:0]           w_valid_flags;
    logic signed [2*SW-1:0]   w_prod;
    logic signed [ACCW-1:0]   w_acc_next;
    logic                     w_mac_last;
    logic                     w_coef_we, w_shift_en, w_clear, w_res_rd;
    logic                     w_unused;

    assign udev_req_ready = r_run && (r_state == ST_IDLE);
    assign w_accept       = udev_req_valid && udev_req_ready;

    assign w_op        = udev_req_cmd[4:0];
    assign w_a         = udev_req_dstaddr[11:0];
    assign w_is_rd     = (w_op == REQ_READ);
    assign w_is_wr     = (w_op == REQ_WRITE);
    assign w_is_post   = (w_op == REQ_POSTED);
    assign w_is_any_wr = w_is_wr || w_is_post;
    assign w_op_ok     = w_is_rd || w_is_any_wr;

    // Channel index lives in addr[9:4]; tap index in addr[9:3].
    assign w_ch     = w_a[4 +: CHW];
    assign w_tap    = w_a[3 +: TW];
    assign w_ch_ok  = (w_a[9:4] < 6'(NCH));
    assign w_tap_ok = (w_a[9:3] < 7'(NTAPS));

    assign w_sel_status = (w_a == ADDR_STATUS);
    assign w_sel_sample = (w_a[11:10] == ADDR_SAMPLE[11:10]) &&
                          (w_a[3:0] == ADDR_SAMPLE[3:0]) && w_ch_ok;
    assign w_sel_result = (w_a[11:10] == ADDR_RESULT[11:10]) &&
                          (w_a[3:0] == ADDR_RESULT[3:0]) && w_ch_ok;
    assign w_sel_coef   = (w_a[11:10] == ADDR_COEF[11:10]) && !w_sel_status &&
                          (w_a[2:0] == 3'b000) && w_tap_ok;
    assign w_addr_ok    = w_is_rd ? (w_sel_result || w_sel_coef || w_sel_status)
                                  : (w_sel_sample || w_sel_coef || w_sel_status);

    assign w_coef_we  = w_accept && w_is_any_wr && w_sel_coef;
    assign w_shift_en = w_accept && w_is_any_wr && w_sel_sample;
    assign w_clear    = w_accept && w_is_any_wr && w_sel_status;
    assign w_res_rd   = w_accept && w_is_rd && w_sel_result;

    always_comb begin
        w_rdata = '0;
        if (w_sel_result)      w_rdata = DW'($signed(w_res_rdata));
        else if (w_sel_coef)   w_rdata = DW'($signed(w_coef_rdata));
        else if (w_sel_status) w_rdata = DW'({w_valid_flags, r_err});
    end

    always_comb begin
        w_resp_cmd        = '0;
        w_resp_cmd[15:5]  = udev_req_cmd[15:5];
        w_resp_cmd[4:0]   = w_is_rd ? RESP_READ : RESP_WRITE;
    end

    assign w_prod     = $signed(w_mac_coef) * $signed(w_mac_x);
    assign w_acc_next = r_acc + ACCW'(w_prod);
    assign w_mac_last = (r_state == ST_MAC) && (r_tap == TW'(NTAPS - 1));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept && w_op_ok) begin
                    if (w_is_any_wr && w_sel_sample) w_next = ST_MAC;
                    else if (w_is_rd || w_is_wr)     w_next = ST_RESP;
                end
            end
            ST_MAC:  if (w_mac_last) w_next = r_mac_posted ? ST_IDLE : ST_RESP;
            ST_RESP: if (udev_resp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_run        <= 1'b0;
            r_err        <= 1'b0;
            r_tap        <= '0;
            r_acc        <= '0;
            r_mac_ch     <= '0;
            r_mac_posted <= 1'b0;
            r_resp_cmd   <= '0;
            r_resp_dst   <= '0;
            r_resp_src   <= '0;
            r_resp_data  <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_clear)
                r_err <= 1'b0;
            else if (w_accept && (!w_op_ok || !w_addr_ok))
                r_err <= 1'b1;
            if (w_accept) begin
                r_tap        <= '0;
                r_acc        <= '0;
                r_mac_ch     <= w_ch;
                r_mac_posted <= w_is_post;
                r_resp_cmd   <= w_resp_cmd;
                r_resp_dst   <= udev_req_srcaddr;
                r_resp_src   <= udev_req_dstaddr;
                r_resp_data  <= w_is_rd ? w_rdata : '0;
            end else if (r_state == ST_MAC) begin
                r_tap <= r_tap + 1'b1;
                r_acc <= w_acc_next;
            end
        end
    end

    assign udev_resp_valid   = (r_state == ST_RESP);
    assign udev_resp_cmd     = r_resp_cmd;
    assign udev_resp_dstaddr = r_resp_dst;
    assign udev_resp_srcaddr = r_resp_src;
    assign udev_resp_data    = r_resp_data;

    umi_fir_bank_regs #(
        .NCH   (NCH),
        .NTAPS (NTAPS),
        .SW    (SW),
        .ACCW  (ACCW),
        .CHW   (CHW),
        .TW    (TW)
    ) u_regs (
        .clk         (clk),
        .nreset      (nreset),
        .clear       (w_clear),
        .coef_we     (w_coef_we),
        .coef_widx   (w_tap),
        .coef_wdata  (udev_req_data[SW-1:0]),
        .coef_ridx   (w_tap),
        .coef_rdata  (w_coef_rdata),
        .shift_en    (w_shift_en),
        .shift_ch    (w_ch),
        .shift_data  (udev_req_data[SW-1:0]),
        .mac_ch      (r_mac_ch),
        .mac_tap     (r_tap),
        .mac_coef    (w_mac_coef),
        .mac_x       (w_mac_x),
        .res_we      (w_mac_last),
        .res_wch     (r_mac_ch),
        .res_wdata   (w_acc_next),
        .res_rd      (w_res_rd),
        .res_rch     (w_ch),
        .res_rdata   (w_res_rdata),
        .valid_flags (w_valid_flags)
    );

    // Upper command, address and data bits carry nothing this block decodes.
    assign w_unused = ^{udev_req_cmd, udev_req_dstaddr, udev_req_data};

endmodule : umi_fir_bank
`default_nettype wire
